// File: rtl/symbol_aligner_pkg.sv
// Shared constants and types for the 8b/10b K28.5 symbol aligner.
package symbol_align_pkg;

  localparam logic [9:0] K28P = 10'b0011111010;
  localparam logic [9:0] K28N = 10'b1100000101;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  function automatic logic is_k28(input logic [9:0] sym);
    return (sym == K28P) || (sym == K28N);
  endfunction

endpackage

// File: rtl/symbol_aligner_if.sv
// Raw-word input and aligned-word output bundle of the symbol aligner.
interface symbol_aligner_if #(
  parameter int unsigned SYMS = 2
);
  localparam int unsigned W = 10 * SYMS;

  logic            in_valid;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [SYMS-1:0] comma_mask;
  logic            locked;
  logic [3:0]      offset;
  logic            realign;

  modport master (
    output in_valid, in_data,
    input  out_valid, out_data, comma_mask, locked, offset, realign
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, out_data, comma_mask, locked, offset, realign
  );
endinterface

// File: rtl/symbol_aligner_comma_search.sv
// Combinational K28.5 search over all W bit positions; lowest position wins.
module comma_search
  import symbol_align_pkg::*;
#(
  parameter int unsigned SYMS = 2
) (
  // low W+9 bits of the {prev, in_data} window: every 10-bit slice starting at 0..W-1
  input  logic [10*SYMS+8:0] i_win,
  output logic               o_found,
  output logic [3:0]         o_o,
  output logic [5:0]         o_p
);
  localparam int unsigned W = 10 * SYMS;

  always_comb begin
    o_found = 1'b0;
    o_o     = '0;
    o_p     = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (!o_found && is_k28(i_win[i +: 10])) begin
        o_found = 1'b1;
        o_o     = 4'(i % 10);
        o_p     = 6'(i);
      end
    end
  end

endmodule

// File: rtl/symbol_aligner.sv
// 8b/10b symbol aligner: comma search, lock FSM and barrel shifter.
// Optional SYMBOL_ALIGNER_DBG_EN adds the misalign_cnt wrong-offset comma counter.
module symbol_aligner
  import symbol_align_pkg::*;
#(
  parameter int unsigned SYMS     = 2,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned LOSS_CNT = 4
) (
  input  logic              clk,
  input  logic              reset,
  symbol_aligner_if.slave   bus
`ifdef SYMBOL_ALIGNER_DBG_EN
  ,
  output logic [15:0]       misalign_cnt
`endif
);
  localparam int unsigned W      = 10 * SYMS;
  localparam logic [3:0]  LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0]  LOSS_N = 4'(LOSS_CNT);

  logic [W-2:0]    r_prev;
  align_state_t    r_state;
  logic [3:0]      r_cand;
  logic [3:0]      r_cnt;
  logic [3:0]      r_bad;
  logic [3:0]      r_offset;
  logic            r_realign;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [SYMS-1:0] r_comma_mask;

  logic [2*W-2:0]  w_win;
  logic            w_found;
  logic [3:0]      w_o;
  logic [5:0]      w_p;
  align_state_t    w_state_nxt;
  logic [3:0]      w_cand_nxt;
  logic [3:0]      w_cnt_nxt;
  logic [3:0]      w_bad_nxt;
  logic [3:0]      w_offset_nxt;
  logic            w_lock_entry;
  logic [W-1:0]    w_aligned;
  logic [SYMS-1:0] w_mask;

  assign w_win = {r_prev, bus.in_data};

  comma_search #(.SYMS(SYMS)) u_search (
    .i_win   (w_win[W+8:0]),
    .o_found (w_found),
    .o_o     (w_o),
    .o_p     (w_p)
  );

  always_comb begin
    if (w_found) assert (w_o == 4'(w_p % 6'd10));
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_cnt_nxt    = r_cnt;
    w_bad_nxt    = r_bad;
    w_offset_nxt = r_offset;
    w_lock_entry = 1'b0;
    if (bus.in_valid && w_found) begin
      unique case (r_state)
        HUNT: begin
          if (LOCK_N == 4'd1) begin
            w_state_nxt  = LOCKED;
            w_offset_nxt = w_o;
            w_cnt_nxt    = '0;
            w_lock_entry = 1'b1;
          end else begin
            w_state_nxt = VERIFY;
            w_cand_nxt  = w_o;
            w_cnt_nxt   = 4'd1;
          end
        end
        VERIFY: begin
          if (w_o == r_cand) begin
            if (r_cnt + 4'd1 >= LOCK_N) begin
              w_state_nxt  = LOCKED;
              w_offset_nxt = r_cand;
              w_cnt_nxt    = '0;
              w_lock_entry = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else begin
            w_cand_nxt = w_o;
            w_cnt_nxt  = 4'd1;
          end
        end
        LOCKED: begin
          if (w_o == r_offset) begin
            w_bad_nxt = '0;
          end else if (r_bad + 4'd1 >= LOSS_N) begin
            w_state_nxt = HUNT;
            w_bad_nxt   = '0;
          end else begin
            w_bad_nxt = r_bad + 4'd1;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // Shift with the post-transition offset so the lock-completing word is already aligned.
  assign w_aligned = w_win[w_offset_nxt +: W];

  always_comb begin
    w_mask = '0;
    for (int unsigned k = 0; k < SYMS; k++) begin
      w_mask[k] = is_k28(w_aligned[10*k +: 10]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev       <= '0;
      r_state      <= HUNT;
      r_cand       <= '0;
      r_cnt        <= '0;
      r_bad        <= '0;
      r_offset     <= '0;
      r_realign    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_comma_mask <= '0;
    end else begin
      r_out_valid <= bus.in_valid && (w_state_nxt == LOCKED);
      r_realign   <= w_lock_entry && (w_offset_nxt != r_offset);
      if (bus.in_valid) begin
        r_prev       <= bus.in_data[W-2:0];
        r_state      <= w_state_nxt;
        r_cand       <= w_cand_nxt;
        r_cnt        <= w_cnt_nxt;
        r_bad        <= w_bad_nxt;
        r_offset     <= w_offset_nxt;
        r_out_data   <= w_aligned;
        r_comma_mask <= w_mask;
      end
    end
  end

`ifdef SYMBOL_ALIGNER_DBG_EN
  logic [15:0] r_misalign;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign <= '0;
    end else if (bus.in_valid && w_found && (r_state == LOCKED) &&
                 (w_o != r_offset) && (r_misalign != '1)) begin
      r_misalign <= r_misalign + 16'd1;
    end
  end

  assign misalign_cnt = r_misalign;
`endif

  assign bus.out_valid  = r_out_valid;
  assign bus.out_data   = r_out_data;
  assign bus.comma_mask = r_comma_mask;
  assign bus.locked     = (r_state == LOCKED);
  assign bus.offset     = r_offset;
  assign bus.realign    = r_realign;

endmodule

// File: tb/tb_symbol_aligner.sv
// Scoreboard bench for symbol_aligner: serial bit-stream model, expectations queued per driven cycle.
module tb_symbol_aligner;

  localparam int SYMS = 2;
  localparam int W    = 10 * SYMS;
  localparam int LOCK = 3;
  localparam int LOSS = 4;
  localparam logic [9:0] COMMA = 10'b0011111010;
  localparam logic [9:0] FILL  = 10'b1010101010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  symbol_aligner_if #(.SYMS(SYMS)) bus ();
`ifdef SYMBOL_ALIGNER_DBG_EN
  logic [15:0] misalign_cnt;
`endif

  symbol_aligner #(
    .SYMS     (SYMS),
    .LOCK_CNT (LOCK),
    .LOSS_CNT (LOSS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SYMBOL_ALIGNER_DBG_EN
    ,
    .misalign_cnt (misalign_cnt)
`endif
  );

  typedef struct {
    logic            ov;
    logic            lk;
    logic [3:0]      off;
    logic            rl;
    logic [W-1:0]    d;
    logic [SYMS-1:0] m;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // serial stream: bit 0 is received first; cst holds comma start indices
  bit sbits[$];
  int cst[$];
  int rd_pos = 0;
  int base   = 0;
  bit last_bit = 1'b0;

  int              m_state, m_cand, m_cnt, m_bad, m_off, m_mis;
  logic [W-1:0]    m_data;
  logic [SYMS-1:0] m_mask;

  function automatic bit sb(input int i);
    if (i < base || i >= sbits.size()) return 1'b0;
    return sbits[i];
  endfunction

  function automatic bit is_cst(input int s);
    if (s < base) return 1'b0;
    foreach (cst[i]) if (cst[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic slip(input int k);
    repeat (k) begin
      last_bit = ~last_bit;
      sbits.push_back(last_bit);
    end
  endtask

  task automatic add_sym(input bit is_comma);
    logic [9:0] v;
    v = is_comma ? COMMA : FILL;
    if (is_comma) cst.push_back(sbits.size());
    for (int b = 9; b >= 0; b--) sbits.push_back(v[b]);
    last_bit = v[0];
  endtask

  task automatic add_group();
    add_sym(1'b1);
    repeat (4 * SYMS - 1) add_sym(1'b0);
  endtask

  task automatic pad_to(input int m, input int r);
    while ((sbits.size() % m) != r) slip(1);
  endtask

  task automatic model_reset();
    m_state = 0; m_cand = 0; m_cnt = 0; m_bad = 0; m_off = 0; m_mis = 0;
    m_data = '0; m_mask = '0;
    base = rd_pos;
  endtask

  task automatic drive_word();
    logic [W-1:0] d;
    int best, o;
    bit rl;
    exp_t e;
    for (int j = 0; j < W; j++) d[W-1-j] = sbits[rd_pos + j];
    best = -1000;
    foreach (cst[i])
      if (cst[i] >= base && cst[i] >= rd_pos - 9 && cst[i] <= rd_pos + W - 10 && cst[i] > best)
        best = cst[i];
    o  = (10 - (best % 10)) % 10;
    rl = 1'b0;
    if (best >= 0) begin
      case (m_state)
        0: if (LOCK == 1) begin
             rl = (o != m_off); m_off = o; m_state = 2; m_cnt = 0;
           end else begin
             m_state = 1; m_cand = o; m_cnt = 1;
           end
        1: if (o == m_cand) begin
             m_cnt++;
             if (m_cnt == LOCK) begin
               rl = (m_cand != m_off); m_off = m_cand; m_state = 2; m_cnt = 0;
             end
           end else begin
             m_cand = o; m_cnt = 1;
           end
        default: if (o == m_off) m_bad = 0;
           else begin
             m_bad++; m_mis++;
             if (m_bad == LOSS) begin m_state = 0; m_bad = 0; end
           end
      endcase
    end
    for (int j = 0; j < W; j++) m_data[W-1-j] = sb(rd_pos - m_off + j);
    for (int k = 0; k < SYMS; k++) m_mask[k] = is_cst(rd_pos - m_off + (SYMS - 1 - k) * 10);
    e = '{ov: (m_state == 2), lk: (m_state == 2), off: 4'(m_off), rl: rl, d: m_data, m: m_mask};
    @(negedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    sb_q.push_back(e);
    rd_pos += W;
  endtask

  task automatic drive_idle();
    logic [W-1:0] junk;
    exp_t e;
    junk = W'($urandom);
    e = '{ov: 1'b0, lk: (m_state == 2), off: 4'(m_off), rl: 1'b0, d: m_data, m: m_mask};
    @(negedge clk); #1;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = junk;
    sb_q.push_back(e);
  endtask

  task automatic drive_avail(input bit sparse);
    while (rd_pos + W <= sbits.size()) begin
      drive_word();
      if (sparse) drive_idle();
    end
  endtask

  task automatic do_reset(input int n, input bit valid_during);
    exp_t z;
    z = '{ov: 1'b0, lk: 1'b0, off: 4'd0, rl: 1'b0, d: '0, m: '0};
    repeat (n) begin
      @(negedge clk); #1;
      reset = 1'b1;
      bus.in_valid = valid_during;
      bus.in_data  = W'($urandom);
      sb_q.push_back(z);
    end
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if ({bus.out_valid, bus.locked, bus.offset, bus.realign} !== {e.ov, e.lk, e.off, e.rl}) begin
        n_fail++;
        $display("FAIL status t=%0t actual ov=%b lk=%b off=%0d rl=%b required ov=%b lk=%b off=%0d rl=%b",
                 $time, bus.out_valid, bus.locked, bus.offset, bus.realign, e.ov, e.lk, e.off, e.rl);
      end
      n_checks++;
      if ({bus.out_data, bus.comma_mask} !== {e.d, e.m}) begin
        n_fail++;
        $display("FAIL data t=%0t actual data=%h mask=%b required data=%h mask=%b",
                 $time, bus.out_data, bus.comma_mask, e.d, e.m);
      end
    end
  end

  task automatic expect_lock(input string name, input logic lk, input logic [3:0] off);
    @(posedge clk); #1;
    n_checks++;
    if (bus.locked !== lk || bus.offset !== off) begin
      n_fail++;
      $display("FAIL %s actual locked=%b offset=%0d required locked=%b offset=%0d",
               name, bus.locked, bus.offset, lk, off);
    end
  endtask

  task automatic test_reset();
    do_reset(2, 1'b0);
    drive_idle();
    @(posedge clk); #1;
    n_checks++;
    if ({bus.locked, bus.out_valid, bus.offset, bus.realign, bus.comma_mask} !== '0) begin
      n_fail++;
      $display("FAIL reset_state actual lk=%b ov=%b off=%0d rl=%b mask=%b required all zero",
               bus.locked, bus.out_valid, bus.offset, bus.realign, bus.comma_mask);
    end
  endtask

  task automatic test_lock_acquire();
    pad_to(10, 7);
    repeat (3) add_group();
    drive_avail(1'b0);
    expect_lock("lock_acquire", 1'b1, 4'd3);
  endtask

  task automatic test_loss_relock();
    slip(6);
    repeat (4) add_group();
    drive_avail(1'b0);
    expect_lock("loss_after_4", 1'b0, 4'd3);
    repeat (3) add_group();
    drive_avail(1'b0);
    expect_lock("relock_at_7", 1'b1, 4'd7);
  endtask

  task automatic test_bad_reset();
    slip(6);
    repeat (3) add_group();
    slip(4);
    add_group();
    slip(6);
    repeat (3) add_group();
    drive_avail(1'b0);
    expect_lock("bad_counter_reset", 1'b1, 4'd7);
`ifdef SYMBOL_ALIGNER_DBG_EN
    n_checks++;
    if (misalign_cnt !== 16'(m_mis)) begin
      n_fail++;
      $display("FAIL misalign_cnt actual=%0d required=%0d", misalign_cnt, m_mis);
    end
`endif
  endtask

  task automatic test_straddle();
    do_reset(1, 1'b1);
    drive_idle();
    repeat (3) begin
      pad_to(W, W - 5);
      add_sym(1'b1);
      add_sym(1'b0);
      add_sym(1'b0);
    end
    drive_avail(1'b0);
    expect_lock("straddle_lock", 1'b1, 4'd5);
  endtask

  task automatic test_sparse_valid();
    do_reset(1, 1'b0);
    drive_idle();
    pad_to(10, 7);
    repeat (3) add_group();
    drive_avail(1'b1);
    expect_lock("sparse_lock", 1'b1, 4'd3);
  endtask

  task automatic test_reset_locked();
    do_reset(1, 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (bus.locked !== 1'b0 || bus.out_valid !== 1'b0 || bus.offset !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_locked actual lk=%b ov=%b off=%0d required lk=0 ov=0 off=0",
               bus.locked, bus.out_valid, bus.offset);
    end
`ifdef SYMBOL_ALIGNER_DBG_EN
    n_checks++;
    if (misalign_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_misalign actual=%0d required=0", misalign_cnt);
    end
`endif
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    model_reset();
    test_reset();
    test_lock_acquire();
    test_loss_relock();
    test_bad_reset();
    test_straddle();
    test_sparse_valid();
    test_reset_locked();
    repeat (3) @(negedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
